// File: rtl/mmio_pkg.sv
// mmio_pkg: shared IO-region constants for the mmio bus bridge
package mmio_pkg;
  localparam logic [3:0] IO_BASE = 4'hF;
  localparam logic [2:0] OFF_LED = 3'd0;
  localparam logic [2:0] OFF_TX = 3'd1;
  localparam logic [2:0] OFF_STAT = 3'd2;
  localparam logic [2:0] OFF_TMR = 3'd3;
  localparam logic [2:0] OFF_CMP = 3'd4;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_IRQ = 3;
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/mmio_bus_bridge_if.sv
// mmio_bus_bridge_if: CPU data bus, RAM port and TX byte stream of the bridge
interface mmio_bus_bridge_if #(parameter int RAM_AW = 10);
  logic MemW;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output MemW, Addr_in, Data_in, ram_dout, tx_ready,
                 input Data_out, ram_we, ram_addr, ram_din, tx_data, tx_valid);
  modport slave(input MemW, Addr_in, Data_in, ram_dout, tx_ready,
                output Data_out, ram_we, ram_addr, ram_din, tx_data, tx_valid);
endinterface

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: show-ahead byte FIFO; caller guarantees no push while full without pop
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_pop;
  assign do_pop = pop & ~empty;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: steers CPU data accesses to RAM or IO registers (LED, TX FIFO, STATUS)
// Optional timer/compare/irq block enabled by defining MMIO_TIMER_EN.
module mmio_bus_bridge import mmio_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int RAM_AW = 10,
  parameter logic [3:0] IO_BASE = mmio_pkg::IO_BASE
) (
  input  logic clk,
  input  logic reset,
  mmio_bus_bridge_if.slave bus,
  output logic [15:0] led_out,
  output logic irq
);
  logic io_sel, we, pop, push, full, empty, ovf, unused;
  logic [2:0] off;
  logic [31:0] io_rdata, status, tmr_q, cmp_q;
  logic irq_q;
  assign io_sel = bus.Addr_in[31:28] == IO_BASE;
  assign off = bus.Addr_in[4:2];
  assign we = bus.MemW & io_sel;
  assign pop = bus.tx_valid & bus.tx_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push = we & off == OFF_TX & (~full | pop);
  assign bus.tx_valid = ~empty;
  assign bus.ram_we = bus.MemW & ~io_sel;
  assign bus.ram_addr = bus.Addr_in[RAM_AW+1:2];
  assign bus.ram_din = bus.Data_in;
  assign status = {28'b0, irq_q, ovf, full, empty};
  assign irq = irq_q;
  assign unused = ^{bus.Addr_in[27:RAM_AW+2], bus.Addr_in[1:0]};
  always_comb
    io_rdata = off == OFF_LED  ? {16'b0, led_out} :
               off == OFF_STAT ? status :
               off == OFF_TMR  ? tmr_q :
               off == OFF_CMP  ? cmp_q : '0;
  assign bus.Data_out = io_sel ? io_rdata : bus.ram_dout;
  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(bus.Data_in[7:0]),
    .head(bus.tx_data),
    .empty(empty),
    .full(full)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      led_out <= '0;
      ovf <= 1'b0;
    end else begin
      if (we & off == OFF_LED) led_out <= bus.Data_in[15:0];
      ovf <= (we & off == OFF_TX & full & ~pop) |
             (ovf & ~(we & off == OFF_STAT & bus.Data_in[ST_OVF]));
    end
`ifdef MMIO_TIMER_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tmr_q <= '0;
      cmp_q <= CMP_RST;
      irq_q <= 1'b0;
    end else begin
      tmr_q <= we & off == OFF_TMR ? bus.Data_in : tmr_q + 32'd1;
      cmp_q <= we & off == OFF_CMP ? bus.Data_in : cmp_q;
      irq_q <= (tmr_q == cmp_q) | (irq_q & ~(we & off == OFF_STAT & bus.Data_in[ST_IRQ]));
    end
`else
  assign tmr_q = '0;
  assign cmp_q = '0;
  assign irq_q = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge: directed and random checks of mmio_bus_bridge against a queue-based model
module tb_mmio_bus_bridge;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] led_out;
  logic irq;
  int vectors = 0;
  int errs = 0;
  logic [15:0] m_led;
  logic [7:0] q[$];
  logic m_ovf, m_irq;
  logic [31:0] m_cnt, m_cmp;

  mmio_bus_bridge_if #(.RAM_AW(10)) bus();
  mmio_bus_bridge #(.FIFO_DEPTH(DEPTH), .RAM_AW(10)) dut (
    .clk(clk), .reset(reset), .bus(bus), .led_out(led_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = '0;
    q.delete();
    m_ovf = 1'b0;
    m_irq = 1'b0;
    m_cnt = '0;
    m_cmp = 32'hFFFF_FFFF;
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [31:0] rd);
    if (a[31:28] != 4'hF) return rd;
    case (a[4:2])
      3'd0: return {16'h0, m_led};
      3'd2: return {28'h0, m_irq, m_ovf, q.size() == DEPTH, q.size() == 0};
`ifdef MMIO_TIMER_EN
      3'd3: return m_cnt;
      3'd4: return m_cmp;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit io, pop, pushed, oset, oclr, iclr, iset;
    logic [2:0] o;
    io = a[31:28] == 4'hF;
    o = a[4:2];
    pop = q.size() != 0 && rdy;
    pushed = 0; oset = 0; oclr = 0; iclr = 0; iset = 0;
    if (w && io) begin
      if (o == 3'd0) m_led = d[15:0];
      if (o == 3'd1) begin
        if (q.size() < DEPTH || pop) pushed = 1;
        else oset = 1;
      end
      if (o == 3'd2) begin
        oclr = d[2];
        iclr = d[3];
      end
    end
    if (pop) void'(q.pop_front());
    if (pushed) q.push_back(d[7:0]);
    m_ovf = oset | (m_ovf & ~oclr);
`ifdef MMIO_TIMER_EN
    iset = m_cnt == m_cmp;
    m_cnt = (w && io && o == 3'd3) ? d : m_cnt + 32'd1;
    if (w && io && o == 3'd4) m_cmp = d;
`endif
    m_irq = iset | (m_irq & ~iclr);
  endtask

  // starts and ends on a falling edge; checks outputs mid-cycle, then steps the model at the rising edge
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic [31:0] rd);
    bus.MemW = w;
    bus.Addr_in = a;
    bus.Data_in = d;
    bus.tx_ready = rdy;
    bus.ram_dout = rd;
    #1;
    chk("rd_data", bus.Data_out, exp_rd(a, rd));
    chk("ram_we", 32'(bus.ram_we), 32'(w & (a[31:28] != 4'hF)));
    chk("ram_addr", 32'(bus.ram_addr), 32'(a[11:2]));
    chk("ram_din", bus.ram_din, d);
    chk("led", 32'(led_out), 32'(m_led));
    chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
    chk("irq", 32'(irq), 32'(m_irq));
    @(posedge clk);
    model_update(w, a, d, rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0] o;
    reset = 1'b1;
    bus.MemW = 1'b0;
    bus.Addr_in = '0;
    bus.Data_in = '0;
    bus.tx_ready = 1'b0;
    bus.ram_dout = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 32'h10, 32'h0, 0, 32'hCAFE);
    chk("t1_rd", bus.Data_out, 32'hCAFE);
    chk("t1_addr", 32'(bus.ram_addr), 32'd4);
    chk("t1_we0", 32'(bus.ram_we), 32'd0);
    cycle(1, 32'h10, 32'h1234, 0, 32'hCAFE);
    chk("t1_we1", 32'(bus.ram_we), 32'd1);
    chk("t1_led", 32'(led_out), 32'd0);
    cycle(1, 32'hF000_0000, 32'h1234_A5A5, 0, $urandom);
    chk("t2_led", 32'(led_out), 32'h0000_A5A5);
    cycle(0, 32'hF000_0000, 32'h0, 0, $urandom);
    chk("t2_rd", bus.Data_out, 32'h0000_A5A5);
    for (int i = 1; i <= 9; i++) cycle(1, 32'hF000_0004, 32'(i), 0, $urandom);
    cycle(0, 32'hF000_0008, 32'h0, 0, $urandom);
    chk("t3_stat", bus.Data_out, 32'h6);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_order", 32'(bus.tx_data), 32'(i));
      cycle(0, 32'h0, 32'h0, 1, $urandom);
    end
    chk("t3_empty", 32'(bus.tx_valid), 32'd0);
    cycle(1, 32'hF000_0008, 32'h4, 0, $urandom);
    chk("t3_clr", bus.Data_out, 32'h1);
    for (int i = 0; i < 8; i++) cycle(1, 32'hF000_0004, 32'h10 + 32'(i), 0, $urandom);
    cycle(1, 32'hF000_0004, 32'hAA, 1, $urandom);
    cycle(0, 32'hF000_0008, 32'h0, 0, $urandom);
    chk("t4_stat", bus.Data_out, 32'h2);
    for (int i = 0; i < 7; i++) cycle(0, 32'h0, 32'h0, 1, $urandom);
    chk("t4_last", 32'(bus.tx_data), 32'hAA);
    cycle(0, 32'h0, 32'h0, 1, $urandom);
    chk("t4_empty", 32'(bus.tx_valid), 32'd0);
`ifdef MMIO_TIMER_EN
    cycle(1, 32'hF000_0010, 32'd20, 0, $urandom);
    cycle(1, 32'hF000_000C, 32'd15, 0, $urandom);
    repeat (5) cycle(0, 32'h0, 32'h0, 0, $urandom);
    chk("t5_irq_early", 32'(irq), 32'd0);
    cycle(0, 32'h0, 32'h0, 0, $urandom);
    chk("t5_irq_set", 32'(irq), 32'd1);
    cycle(1, 32'hF000_0008, 32'h8, 0, $urandom);
    chk("t5_irq_clr", 32'(irq), 32'd0);
    cycle(1, 32'hF000_000C, 32'hFFFF_FFFF, 0, $urandom);
    cycle(0, 32'hF000_000C, 32'h0, 0, $urandom);
    chk("t5_wrap", bus.Data_out, 32'h0);
`else
    cycle(1, 32'hF000_000C, 32'h1234, 0, $urandom);
    cycle(0, 32'hF000_000C, 32'h0, 0, $urandom);
    chk("t5_tmr_rd", bus.Data_out, 32'h0);
    chk("t5_irq", 32'(irq), 32'd0);
`endif
    cycle(1, 32'hF000_0000, 32'h5A5A, 0, $urandom);
    for (int i = 0; i < 3; i++) cycle(1, 32'hF000_0004, 32'h30 + 32'(i), 0, $urandom);
    cycle(0, 32'h0, 32'h0, 1, $urandom);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.tx_valid), 32'd0);
    chk("t6_led", 32'(led_out), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (400) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) != 0) ? {4'hF, 23'($urandom), o, 2'($urandom)}
                                      : {4'($urandom_range(0, 14)), 28'($urandom)};
      cycle(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2) == 0, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
